// File: rtl/clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_ctrl
//   Decides when a downstream hard clock gate may turn its clock off. The block
//   watches an activity indication, gates the clock after a programmable run of
//   idle cycles (or on an explicit sleep request), and brings the clock back
//   through a fixed-length WAKE phase so the downstream logic sees a clean
//   restart. A saturating counter records how many times the clock was gated.
//
// Parameters
//   IDLE_W   width of the idle threshold and of the idle counter
//   WAKE_DLY number of cycles spent in WAKE before returning to RUN (1..255)
//   CNT_W    width of the gating-event counter
//
// Ports
//   i_clk          sole clock, rising edge
//   i_rst_n        synchronous active-low reset
//   i_busy         downstream activity, 1 = clock needed
//   i_idle_thresh  idle cycles before auto-gating, 0 disables auto-gating
//   i_sleep_req    forced gate-off request (level)
//   i_wake_req     explicit wake request (level)
//   i_bypass       forces the clock on and the FSM to RUN
//   o_clk_en       enable for the hard clock gate, 1 = clock running
//   o_wake_done    one-cycle pulse on the first RUN cycle after WAKE
//   o_state        RUN=0, OFF=1, WAKE=2
//   o_gate_evt_cnt saturating count of RUN->OFF transitions
// -----------------------------------------------------------------------------
module clk_gate_ctrl #(
  parameter int IDLE_W   = 8,
  parameter int WAKE_DLY = 2,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_busy,
  input  logic [IDLE_W-1:0] i_idle_thresh,
  input  logic              i_sleep_req,
  input  logic              i_wake_req,
  input  logic              i_bypass,
  output logic              o_clk_en,
  output logic              o_wake_done,
  output logic [1:0]        o_state,
  output logic [CNT_W-1:0]  o_gate_evt_cnt
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_OFF  = 2'd1;
  localparam logic [1:0] ST_WAKE = 2'd2;

  // Value of the wake counter on the last WAKE cycle.
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_DLY - 1);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        wake_cnt;
  logic [CNT_W-1:0]  gate_cnt;
  logic              wake_done;

  logic              to_off;
  logic              wake_finish;
  logic [IDLE_W:0]   idle_plus1;
  logic              thresh_hit;

  function automatic logic [IDLE_W-1:0] idle_sat_inc(input logic [IDLE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] gate_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // One extra bit so idle_cnt+1 cannot wrap when the counter is saturated;
  // the live threshold is used so lowering it takes effect immediately.
  assign idle_plus1 = {1'b0, idle_cnt} + {{IDLE_W{1'b0}}, 1'b1};
  assign thresh_hit = (i_idle_thresh != '0) && (idle_plus1 >= {1'b0, i_idle_thresh});

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_RUN;
      wake_done <= 1'b0;
    end else begin
      state     <= next_state;
      wake_done <= wake_finish;
    end
  end

  // Next-state logic; bypass overrides everything and never produces a
  // gating event or a wake_done pulse.
  always_comb begin
    next_state  = state;
    to_off      = 1'b0;
    wake_finish = 1'b0;
    if (i_bypass) begin
      next_state = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          // busy always wins over sleep and over the idle threshold
          if (!i_busy && (i_sleep_req || thresh_hit)) begin
            next_state = ST_OFF;
            to_off     = 1'b1;
          end
        end
        ST_OFF: begin
          if (i_busy || i_wake_req) begin
            next_state = ST_WAKE;
          end
        end
        ST_WAKE: begin
          // inputs are ignored here: a wake sequence always runs to completion
          if (wake_cnt == WAKE_LAST) begin
            next_state  = ST_RUN;
            wake_finish = 1'b1;
          end
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  // Output decode, purely from registered state
  always_comb begin
    o_clk_en       = (state != ST_OFF);
    o_state        = state;
    o_wake_done    = wake_done;
    o_gate_evt_cnt = gate_cnt;
  end

  // Idle, wake and gating-event counters
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      idle_cnt <= '0;
      wake_cnt <= '0;
      gate_cnt <= '0;
    end else begin
      if (to_off) begin
        gate_cnt <= gate_sat_inc(gate_cnt);
      end

      if (i_bypass || (state != ST_RUN && next_state == ST_RUN)) begin
        idle_cnt <= '0;
      end else if (state == ST_RUN) begin
        idle_cnt <= i_busy ? '0 : idle_sat_inc(idle_cnt);
      end

      if (i_bypass || (state == ST_OFF && next_state == ST_WAKE)) begin
        wake_cnt <= '0;
      end else if (state == ST_WAKE) begin
        wake_cnt <= wake_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_gate_ctrl
//   Directed bench. The stimulus process drives inputs, waits for the clock
//   edge and queues the hand-computed outputs expected after that edge; the
//   monitor pops one entry on every falling edge and compares it with the DUT.
//   The DUT is built with CNT_W=2 so the event counter saturates quickly.
// -----------------------------------------------------------------------------
module tb_clk_gate_ctrl;

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] OFF  = 2'd1;
  localparam logic [1:0] WAKE = 2'd2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [7:0] idle_thresh;
  logic       sleep_req;
  logic       wake_req;
  logic       bypass;
  logic       clk_en;
  logic       wake_done;
  logic [1:0] state;
  logic [1:0] gate_evt_cnt;

  typedef struct {
    string      name;
    logic [1:0] st;
    logic       wd;
    logic [1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .IDLE_W  (8),
    .WAKE_DLY(2),
    .CNT_W   (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_busy        (busy),
    .i_idle_thresh (idle_thresh),
    .i_sleep_req   (sleep_req),
    .i_wake_req    (wake_req),
    .i_bypass      (bypass),
    .o_clk_en      (clk_en),
    .o_wake_done   (wake_done),
    .o_state       (state),
    .o_gate_evt_cnt(gate_evt_cnt)
  );

  // Monitor: compare the outputs that follow each queued edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      logic exp_en;
      e      = sbq.pop_front();
      exp_en = (e.st != OFF);
      total++;
      if (state !== e.st || clk_en !== exp_en || wake_done !== e.wd || gate_evt_cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s: got state=%0d clk_en=%0b wake_done=%0b cnt=%0d, want state=%0d clk_en=%0b wake_done=%0b cnt=%0d",
                 e.name, state, clk_en, wake_done, gate_evt_cnt, e.st, exp_en, e.wd, e.cnt);
      end
    end
  end

  task automatic step(input string nm, input logic [1:0] st, input logic wd, input logic [1:0] cn);
    exp_t e;
    @(posedge clk);
    #1;
    e.name = nm;
    e.st   = st;
    e.wd   = wd;
    e.cnt  = cn;
    sbq.push_back(e);
  endtask

  initial begin
    int wait_cnt;
    rst_n       = 1'b0;
    busy        = 1'b1;
    idle_thresh = 8'd4;
    sleep_req   = 1'b0;
    wake_req    = 1'b0;
    bypass      = 1'b0;

    step("reset", RUN, 1'b0, 2'd0);

    // Threshold 4, busy low from reset release: gate on the 4th idle edge
    rst_n = 1'b1;
    busy  = 1'b0;
    for (int i = 0; i < 3; i++) step("idle_run", RUN, 1'b0, 2'd0);
    step("idle_gate", OFF, 1'b0, 2'd1);
    step("off_hold", OFF, 1'b0, 2'd1);

    // One-cycle wake request: WAKE for 2 cycles, then one wake_done pulse
    wake_req = 1'b1;
    step("wake_enter", WAKE, 1'b0, 2'd1);
    wake_req = 1'b0;
    step("wake_hold", WAKE, 1'b0, 2'd1);
    step("wake_done", RUN, 1'b1, 2'd1);
    step("wake_done_clr", RUN, 1'b0, 2'd1);

    // Busy pulse after 3 idle cycles restarts the idle count
    step("idle2", RUN, 1'b0, 2'd1);
    step("idle3", RUN, 1'b0, 2'd1);
    busy = 1'b1;
    step("busy_pulse", RUN, 1'b0, 2'd1);
    busy = 1'b0;
    for (int i = 0; i < 3; i++) step("post_pulse_run", RUN, 1'b0, 2'd1);
    step("post_pulse_gate", OFF, 1'b0, 2'd2);

    // Busy with sleep in OFF: wake wins; in WAKE sleep is ignored
    busy      = 1'b1;
    sleep_req = 1'b1;
    step("busy_wake", WAKE, 1'b0, 2'd2);
    busy = 1'b0;
    step("wake_ignore_sleep", WAKE, 1'b0, 2'd2);

    // Bypass on the last WAKE cycle: RUN, no wake_done; gating suppressed
    bypass = 1'b1;
    step("bypass_wake", RUN, 1'b0, 2'd2);
    for (int i = 0; i < 5; i++) step("bypass_hold", RUN, 1'b0, 2'd2);
    bypass = 1'b0;

    // Sleep with busy stays RUN; dropping busy gates on the next edge
    busy = 1'b1;
    step("sleep_busy", RUN, 1'b0, 2'd2);
    busy = 1'b0;
    step("sleep_gate", OFF, 1'b0, 2'd3);
    sleep_req = 1'b0;

    // Bypass from OFF
    bypass = 1'b1;
    step("bypass_off", RUN, 1'b0, 2'd3);
    bypass = 1'b0;

    // Lowering the live threshold below the count gates on the next idle edge
    step("lt_idle1", RUN, 1'b0, 2'd3);
    step("lt_idle2", RUN, 1'b0, 2'd3);
    idle_thresh = 8'd2;
    step("lt_gate_sat", OFF, 1'b0, 2'd3);

    // Reset in OFF, asserted together with bypass
    rst_n  = 1'b0;
    bypass = 1'b1;
    step("reset_off", RUN, 1'b0, 2'd0);
    rst_n  = 1'b1;
    bypass = 1'b0;

    // Threshold 0 and no sleep: RUN indefinitely
    idle_thresh = 8'd0;
    for (int i = 0; i < 6; i++) step("no_thresh", RUN, 1'b0, 2'd0);

    // Sleep with threshold 0, then reset aborts a WAKE without a pulse
    sleep_req = 1'b1;
    step("sleep_thr0", OFF, 1'b0, 2'd1);
    sleep_req = 1'b0;
    wake_req  = 1'b1;
    step("wake2_enter", WAKE, 1'b0, 2'd1);
    wake_req = 1'b0;
    step("wake2_hold", WAKE, 1'b0, 2'd1);
    rst_n = 1'b0;
    step("reset_wake", RUN, 1'b0, 2'd0);
    rst_n = 1'b1;
    step("post_reset", RUN, 1'b0, 2'd0);

    // Five gating events on a 2-bit counter: 1, 2, 3, 3, 3
    sleep_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      logic [1:0] c;
      c        = (k > 3) ? 2'd3 : 2'(k);
      wake_req = 1'b0;
      step("sat_gate", OFF, 1'b0, c);
      wake_req = 1'b1;
      step("sat_wake", WAKE, 1'b0, c);
      wake_req = 1'b0;
      step("sat_wake_hold", WAKE, 1'b0, c);
      step("sat_run", RUN, 1'b1, c);
    end
    sleep_req = 1'b0;

    wait_cnt = 0;
    while (sbq.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

Interface
REQ-001 Parameter IDLE_W, default 8, width of the idle threshold and idle counter.
REQ-002 Parameter WAKE_DLY, default 2, cycles spent in WAKE before RUN; legal range 1..255.
REQ-003 Parameter CNT_W, default 16, width of the gating-event counter.
REQ-004 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 i_busy  input  1  downstream activity indication; 1 = clock needed.
REQ-007 i_idle_thresh  input  IDLE_W  consecutive idle cycles before auto-gating; 0 = auto-gating disabled.
REQ-008 i_sleep_req  input  1  forced gate-off request, level-sampled.
REQ-009 i_wake_req  input  1  explicit wake request, level-sampled.
REQ-010 i_bypass  input  1  forces the clock on and the FSM to RUN.
REQ-011 o_clk_en  output  1  enable for the downstream hard clock gate; 1 = clock running.
REQ-012 o_wake_done  output  1  single-cycle pulse on the first RUN cycle after WAKE.
REQ-013 o_state  output  2  FSM state: RUN=0, OFF=1, WAKE=2; 3 never driven.
REQ-014 o_gate_evt_cnt  output  CNT_W  saturating count of RUN->OFF transitions.

Function
REQ-015 All outputs SHALL be registered or decoded only from registered state; no combinational path from any input to any output.
REQ-016 o_clk_en SHALL be 1 in RUN and WAKE, and 0 in OFF.
REQ-017 In RUN, the idle counter SHALL clear on every edge where i_busy=1 and SHALL increment on every edge where i_busy=0, saturating at all-ones.
REQ-018 In RUN with i_idle_thresh!=0 and i_busy=0, when idle_cnt+1 >= i_idle_thresh, the FSM SHALL go to OFF on that edge; the comparison uses the live threshold, so lowering it below the current count gates on the next idle edge.
REQ-019 In RUN, i_sleep_req=1 with i_busy=0 SHALL go to OFF on the next edge regardless of the threshold; i_busy=1 takes priority over i_sleep_req.
REQ-020 Every RUN->OFF transition SHALL increment o_gate_evt_cnt by 1, holding at all-ones with no wrap.
REQ-021 In OFF, i_busy=1 or i_wake_req=1 SHALL go to WAKE on the next edge and clear the wake counter; wake takes priority over a simultaneous i_sleep_req.
REQ-022 In WAKE, the wake counter SHALL increment each edge; on the edge where it equals WAKE_DLY-1, the FSM SHALL go to RUN with o_wake_done=1 for exactly that one following cycle; WAKE therefore lasts exactly WAKE_DLY cycles.
REQ-023 In WAKE, i_busy, i_sleep_req and i_wake_req SHALL be ignored; a wake sequence cannot be aborted except by i_bypass or reset.
REQ-024 Entering RUN SHALL clear the idle counter.
REQ-025 i_bypass=1 in any state SHALL force RUN on the next edge and clear both counters; it SHALL NOT raise o_wake_done or change o_gate_evt_cnt; while i_bypass=1, RUN->OFF transitions SHALL be suppressed.
REQ-026 With i_idle_thresh=0 and i_sleep_req=0, the FSM SHALL remain in RUN indefinitely.

Reset
REQ-027 On an edge with i_rst_n=0, the block SHALL enter RUN and set o_clk_en=1, o_wake_done=0, o_state=0, o_gate_evt_cnt=0, and both counters to 0.
REQ-028 Reset SHALL take priority over all other inputs, including i_bypass, and SHALL abort any WAKE sequence in progress without producing a wake_done pulse.

Verification
REQ-029 Threshold=4, i_busy held low from reset release -> o_clk_en falls after the 4th idle edge, o_state=1, o_gate_evt_cnt=1.
REQ-030 Threshold=4, i_busy pulses high after 3 idle cycles -> no gating occurs; gating happens 4 idle cycles after the pulse ends.
REQ-031 In OFF, pulse i_wake_req for 1 cycle with WAKE_DLY=2 -> o_state goes 2 for 2 cycles then 0, o_clk_en=1 throughout, o_wake_done high for exactly 1 cycle.
REQ-032 In RUN, assert i_sleep_req and i_busy together -> stays RUN; deassert i_busy -> OFF on the next edge.
REQ-033 Assert i_bypass in WAKE -> RUN on the next edge, o_wake_done stays 0; assert reset in OFF -> RUN, o_clk_en=1, counters 0.
REQ-034 CNT_W=2, force 5 gating events -> o_gate_evt_cnt reads 1, 2, 3, 3, 3.
